// File: rtl/mmio_store_sink.sv
// mmio_store_sink: memory-mapped store sink beside dmem on the MIPS data bus.
//   DATA   (BASE)    : stores are queued into a FIFO, drained via valid/ready.
//   STATUS (BASE+4)  : {overflow, done, full, empty, count}; write bit0=1 clears overflow.
//   DONE   (BASE+8)  : storing DONE_VALUE sets the sticky done flag.
//   CYCLES (BASE+12) : cycle counter, present only with MMIO_STORE_SINK_CYCLES_EN.
// Optional feature macro: MMIO_STORE_SINK_CYCLES_EN.
module mmio_store_sink #(
    parameter int unsigned  N          = 32,
    parameter int unsigned  DEPTH      = 8,
    parameter logic [N-1:0] BASE_ADDR  = 32'h0000_0054,
    parameter logic [N-1:0] DONE_VALUE = 32'h0000_0096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    output logic [N-1:0] readdata,
    output logic         hit,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic         done,
    output logic         overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [N-1:0] STATUS_ADDR = BASE_ADDR + N'(4);
    localparam logic [N-1:0] DONE_ADDR   = BASE_ADDR + N'(8);
    localparam logic [N-1:0] CYCLES_ADDR = BASE_ADDR + N'(12);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d, overflow_q, overflow_d;
    logic          hit_data, hit_stat, hit_done, hit_cyc;
    logic          empty, full, pop, push_req, push, drop, done_set;
    logic [N-1:0]  status_word, cycles_rd;
    logic          unused_adr_lsb;

    // Byte offset within the word is ignored by the decoder.
    assign unused_adr_lsb = ^dataadr[1:0];

    assign hit_data = (dataadr[N-1:2] == BASE_ADDR[N-1:2]);
    assign hit_stat = (dataadr[N-1:2] == STATUS_ADDR[N-1:2]);
    assign hit_done = (dataadr[N-1:2] == DONE_ADDR[N-1:2]);
    assign hit_cyc  = (dataadr[N-1:2] == CYCLES_ADDR[N-1:2]);
    assign hit      = hit_data | hit_stat | hit_done | hit_cyc;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = ~empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign done      = done_q;
    assign overflow  = overflow_q;

    // A simultaneous pop frees a slot, so a full FIFO still accepts the store.
    assign pop      = out_valid & out_ready;
    assign push_req = memwrite & hit_data;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign done_set = memwrite & hit_done & (writedata == DONE_VALUE);

    // Next-state for FIFO storage, pointers, count and sticky flags.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = writedata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        // A drop in the same cycle as a software clear leaves the flag set.
        overflow_d = overflow_q;
        if (memwrite && hit_stat && writedata[0]) overflow_d = 1'b0;
        if (drop) overflow_d = 1'b1;
        done_d = done_q | done_set;
    end

    // State registers; every entry is cleared so out_data is never X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef MMIO_STORE_SINK_CYCLES_EN
    logic [N-1:0] cycles_q, cycles_d;

    // Count run length; stop on (not after) the edge that raises done.
    always_comb begin
        cycles_d = cycles_q;
        if (!done_q && !done_set) cycles_d = cycles_q + N'(1);
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycles_q <= '0;
        else        cycles_q <= cycles_d;
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = '0;
`endif

    // STATUS layout and read mux; unmapped addresses read 0 for dmem's mux.
    always_comb begin
        status_word      = '0;
        status_word[7:0] = 8'(count_q);
        status_word[8]   = empty;
        status_word[9]   = full;
        status_word[10]  = done_q;
        status_word[11]  = overflow_q;
        readdata = '0;
        if (hit_data)      readdata = out_data;
        else if (hit_stat) readdata = status_word;
        else if (hit_done) readdata = {{(N-1){1'b0}}, done_q};
        else if (hit_cyc)  readdata = cycles_rd;
    end
endmodule

// File: tb/tb_mmio_store_sink.sv
// Directed bench for mmio_store_sink with a scoreboard queue of expected
// stream words, pushed as stores are issued and popped on each handshake.
module tb_mmio_store_sink;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        hit;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic        m_ovf = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] rd, c1, c2;

    mmio_store_sink dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(readdata), .hit(hit),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int cnt, input logic d, input logic o);
        logic [31:0] s;
        s = '0;
        s[7:0] = 8'(cnt);
        s[8]   = (cnt == 0);
        s[9]   = (cnt == 8);
        s[10]  = d;
        s[11]  = o;
        return s;
    endfunction

    task automatic rd_reg(input logic [31:0] adr, output logic [31:0] v);
        memwrite = 1'b0;
        dataadr  = adr;
        #1;
        v = readdata;
    endtask

    // Single bus store; the model assumes no concurrent pop (out_ready low).
    task automatic store(input logic [31:0] adr, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = d;
        if (adr[31:2] == 30'h15) begin
            if (sb.size() < 8) sb.push_back(d);
            else m_ovf = 1'b1;
        end
        if (adr[31:2] == 30'h16 && d[0]) m_ovf = 1'b0;
        if (adr[31:2] == 30'h17 && d == 32'h96) m_done = 1'b1;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic drain(input int n);
        logic [31:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("drain_valid", {31'b0, out_valid}, 32'd1);
            e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            check("drain_data", out_data, e);
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        reset = 1'b1;
        tick();
        rd_reg(32'h58, rd);
        check("status_empty", rd, 32'h0000_0100);
        check("hit_status", {31'b0, hit}, 32'd1);
        rd_reg(32'h40, rd);
        check("miss_read", rd, 32'd0);
        check("miss_hit", {31'b0, hit}, 32'd0);

        // Three stores, then drain in order.
        store(32'h54, 32'hA);
        store(32'h54, 32'hB);
        store(32'h54, 32'hC);
        rd_reg(32'h58, rd);
        check("status_cnt3", rd, stat(sb.size(), m_done, m_ovf));
        check("head_A", out_data, 32'hA);
        rd_reg(32'h57, rd);
        check("data_read_lsb_ignored", rd, 32'hA);
        drain(3);
        check("empty_after_drain", {31'b0, out_valid}, 32'd0);

        // Fill past capacity.
        for (int i = 1; i <= 9; i++) store(32'h54, 32'(i));
        rd_reg(32'h58, rd);
        check("status_full_ovf", rd, 32'h0000_0A08);
        check("ovf_flag", {31'b0, overflow}, 32'd1);
        check("head_full", out_data, 32'd1);
        store(32'h58, 32'h1);
        check("ovf_cleared", {31'b0, overflow}, 32'd0);
        rd_reg(32'h58, rd);
        check("status_full", rd, stat(sb.size(), m_done, m_ovf));

        // Push and pop together while full: nothing dropped.
        out_ready = 1'b1;
        memwrite  = 1'b1;
        dataadr   = 32'h54;
        writedata = 32'h55;
        #1;
        check("pp_head", out_data, sb.pop_front());
        sb.push_back(32'h55);
        tick();
        memwrite  = 1'b0;
        out_ready = 1'b0;
        check("pp_no_ovf", {31'b0, overflow}, 32'd0);
        rd_reg(32'h58, rd);
        check("pp_status", rd, 32'h0000_0208);
        drain(8);
        check("pp_empty", {31'b0, out_valid}, 32'd0);

        // Done register.
        store(32'h5C, 32'h95);
        check("done_wrong_val", {31'b0, done}, {31'b0, m_done});
        rd_reg(32'h5C, rd);
        check("done_read0", rd, 32'd0);
        store(32'h5C, 32'h96);
        check("done_set", {31'b0, done}, {31'b0, m_done});
        rd_reg(32'h5C, rd);
        check("done_read1", rd, 32'd1);
        rd_reg(32'h60, c1);
        check("hit_cycles", {31'b0, hit}, 32'd1);
        repeat (3) tick();
        rd_reg(32'h60, c2);
        check("cycles_frozen", c2, c1);
`ifdef MMIO_STORE_SINK_CYCLES_EN
        check("cycles_nonzero", {31'b0, (c1 != 0)}, 32'd1);
`else
        check("cycles_absent", c1, 32'd0);
`endif

        // Asynchronous reset during a drain.
        for (int i = 0; i < 4; i++) store(32'h54, 32'h100 + 32'(i));
        rd_reg(32'h58, rd);
        check("status_cnt4", rd, stat(sb.size(), m_done, m_ovf));
        out_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("async_valid", {31'b0, out_valid}, 32'd0);
        check("async_done", {31'b0, done}, 32'd0);
        sb.delete();
        m_done = 1'b0;
        m_ovf  = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rd_reg(32'h58, rd);
        check("status_after_reset", rd, 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
